pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/sum width in bits (>=1).
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline depth; WIDTH % STAGES == 0 is required, and elaboration SHALL fail otherwise.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready at clk edge.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  raw carry out of MSB.
REQ-015 overflow  output  1  two's-complement signed overflow.

Function
REQ-016 Arithmetic: add gives {cout,sum} = a + b + cin; sub gives {cout,sum} = a + ~b + ~cin, i.e. a - b - cin mod 2^WIDTH, with cout = 1 meaning no borrow.
REQ-017 overflow SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-018 Slicing: stage k (k = 0..STAGES-1) SHALL add bits [k*W/S +: W/S] using the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-019 Skew: not-yet-summed operand slices SHALL be delayed alongside the data, and completed sum slices SHALL be carried forward so all slices of one beat emerge together.
REQ-020 Latency: a beat accepted at edge N SHALL appear with out_valid = 1 after edge N+STAGES-1+1 (STAGES cycles), provided no stall occurs.
REQ-021 Throughput SHALL be one beat per cycle while out_ready = 1.
REQ-022 Stall: when out_valid && !out_ready, every stage register SHALL hold.
REQ-023 in_ready SHALL equal out_ready || !out_valid, combinationally; this is a global stall.
REQ-024 Internal bubbles are not collapsed during a stall.
REQ-025 sum, cout and overflow SHALL be stable while out_valid && !out_ready.
REQ-026 Beats SHALL never be dropped, duplicated or reordered.
REQ-027 When STAGES = 1, the block SHALL degenerate to a single registered adder with the same handshake.
REQ-028 Each stage SHALL carry a valid bit.
REQ-029 A beat with in_valid = 0 SHALL enter as a bubble, and result fields of bubbles are don't-care internally.

Reset
REQ-030 rst SHALL asynchronously clear all stage valid bits, sum, cout and overflow to 0.
REQ-031 After reset, in_ready SHALL be 1.
REQ-032 Assertion of rst mid-operation SHALL discard all in-flight beats, and no beat accepted before reset SHALL appear afterwards.

Structure
REQ-033 Package pipelined_adder_pkg SHALL hold the default WIDTH/STAGES constants and a slice-width function (WIDTH/STAGES).
REQ-034 One sub-module adder_stage (slice add with carry in/out, parametrised slice width) SHALL be instantiated STAGES times via generate.
REQ-035 Pipeline registers SHALL live in the top module.

Verification (WIDTH=8, STAGES=2)
REQ-036 Add: a=8'hFF, b=8'h01, cin=0, sub=0 -> after 2 cycles, sum=8'h00, cout=1, overflow=0.
REQ-037 Signed overflow: a=8'h7F, b=8'h01, cin=0, sub=0 -> sum=8'h80, cout=0, overflow=1.
REQ-038 Subtract: a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=0 (borrow), overflow=0.
REQ-039 Subtract with borrow-in: a=8'h10, b=8'h01, cin=1, sub=1 -> sum=8'h0E, cout=1.
REQ-040 Back-to-back and stall: stream 1+1, 2+2, 3+3 and drop out_ready for 3 cycles after the first result. in_ready SHALL go 0, the output SHALL hold 8'h02, then 8'h04 and 8'h06 SHALL follow in order with none lost.
REQ-041 Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0, and no stale result appears afterwards.
REQ-042 All eight 1-bit cases SHALL also be swept with WIDTH=1, STAGES=1 and the results matched against the full-adder truth table.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and slice-width helper for the pipelined ripple adder.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One slice of the ripple adder: SW-bit add with carry in and carry out.
module adder_stage #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout
);

    logic [SW:0] w_full;

    // Slice sum with one extra bit to capture the carry out
    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};
    end

    assign o_sum  = w_full[SW-1:0];
    assign o_cout = w_full[SW];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipelined over STAGES slices with a global valid/ready stall.
// Rank 0 registers the accepted beat; rank k+1 holds the result of slice k.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int SW = slice_width(WIDTH, STAGES);

    generate
        if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES");
        end
    endgenerate

    logic                          r_v   [0:STAGES];
    logic                          r_c   [0:STAGES];
    logic [WIDTH-1:0]              r_s   [1:STAGES];
    logic [WIDTH-1:0]              r_a   [0:STAGES-1];
    logic [WIDTH-1:0]              r_b   [0:STAGES-1];
    logic                          r_ovf;

    logic                          w_adv;
    logic                          w_cmsb;
    logic [WIDTH-1:0]              w_slice;
    logic [STAGES-1:0]             w_co;
    logic [STAGES-1:0][WIDTH-1:0]  w_base;
    logic [STAGES-1:0][WIDTH-1:0]  w_sum_nx;

    assign w_adv    = out_ready || !r_v[STAGES];
    assign in_ready = w_adv;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            adder_stage #(.SW(SW)) u_stage (
                .i_a    (r_a[k][k*SW +: SW]),
                .i_b    (r_b[k][k*SW +: SW]),
                .i_cin  (r_c[k]),
                .o_sum  (w_slice[k*SW +: SW]),
                .o_cout (w_co[k])
            );
            if (k == 0) begin : g_first
                assign w_base[k] = '0;
            end else begin : g_rest
                assign w_base[k] = r_s[k];
            end
        end
    endgenerate

    // Finished slices ride along; slice k is dropped into its field here
    always_comb begin
        w_sum_nx = w_base;
        for (int i = 0; i < STAGES; i++) begin
            w_sum_nx[i][i*SW +: SW] = w_slice[i*SW +: SW];
        end
    end

    // Sum MSB = a ^ b ^ (carry into MSB), so the carry in can be recovered
    assign w_cmsb = r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1] ^ w_slice[WIDTH-1];

    // Global-stall pipeline: every rank advances together or holds together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= STAGES; i++) begin
                r_v[i] <= 1'b0;
                r_c[i] <= 1'b0;
            end
            for (int i = 1; i <= STAGES; i++) begin
                r_s[i] <= '0;
            end
            for (int i = 0; i < STAGES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            r_a[0] <= a;
            r_b[0] <= sub ? ~b : b;
            r_c[0] <= cin ^ sub;
            for (int i = 0; i < STAGES; i++) begin
                r_v[i+1] <= r_v[i];
                r_c[i+1] <= w_co[i];
                r_s[i+1] <= w_sum_nx[i];
            end
            for (int i = 1; i < STAGES; i++) begin
                r_a[i] <= r_a[i-1];
                r_b[i] <= r_b[i-1];
            end
            r_ovf <= w_cmsb ^ w_co[STAGES-1];
        end
    end

    assign out_valid = r_v[STAGES];
    assign sum       = r_s[STAGES];
    assign cout      = r_c[STAGES];
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 8-bit/2-stage adder plus a 1-bit/1-stage instance.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       cin, sub, cout, overflow;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic       a1, b1, cin1, sub1, sum1, cout1, overflow1;
    logic [9:0] q  [$];
    logic [9:0] q1 [$];
    int         checks = 0;
    int         errors = 0;
    bit         rnd_ready = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .overflow(overflow1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic and signed-range test, result {ovf, cout, sum}
    function automatic logic [9:0] model(input int w, input int ta, input int tb,
                                         input int tc, input int ts);
        int m, ru, sa, sb, rs;
        logic [9:0] res;
        m  = 1 << w;
        ru = ts ? ta - tb - tc : ta + tb + tc;
        res = '0;
        res[7:0] = 8'(((ru % m) + m) % m);
        res[8] = ts ? (ru >= 0) : (ru >= m);
        sa = (ta >= m / 2) ? ta - m : ta;
        sb = (tb >= m / 2) ? tb - m : tb;
        rs = ts ? sa - sb - tc : sa + sb + tc;
        res[9] = (rs < -(m / 2)) || (rs > m / 2 - 1);
        return res;
    endfunction

    // Offer one beat (called at posedge+1); push expectation when accepted
    task automatic send(input bit sel, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, input logic [9:0] exp);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        if (sel) begin
            a1 = ta[0]; b1 = tb[0]; cin1 = tc; sub1 = ts; in_valid1 = 1'b1;
        end else begin
            a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        end
        while (!acc && n < 200) begin
            #2;
            acc = sel ? in_ready1 : in_ready;
            if (acc) begin
                if (sel) q1.push_back(exp);
                else     q.push_back(exp);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready  = 1'b1;
        out_ready1 = 1'b1;
        while ((q.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", q.size() + q1.size(), 0);
    endtask

    // Monitor: compare every presented-and-taken beat against the queue head
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sum=%0h with no beat pending", sum);
                end else begin
                    e = q.pop_front();
                    check("beat8", {22'd0, overflow, cout, sum}, {22'd0, e});
                end
            end
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat1: got sum=%0h with no beat pending", sum1);
                end else begin
                    e = q1.pop_front();
                    check("beat1", {29'd0, overflow1, cout1, sum1}, {29'd0, e[9], e[8], e[0]});
                end
            end
        end
    end

    // Random backpressure while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs, x, y, s, co;
        logic [2:0] v;
        rst = 1'b1;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid1", out_valid1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: accepted at edge N, visible only after edge N+2
        send(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
        in_valid = 1'b0;
        @(negedge clk); check("lat_edge0", out_valid, 0);
        @(negedge clk); check("lat_edge1", out_valid, 0);
        @(negedge clk); check("lat_edge2", out_valid, 1);
        @(posedge clk);
        #1;

        send(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
        send(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE);
        send(1'b0, 8'h10, 8'h01, 1'b1, 1'b1, 10'h10E);
        idle(1);
        drain();

        // Stall: first result must be held while out_ready is low
        out_ready = 1'b0;
        send(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 10'h002);
        send(1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 10'h004);
        send(1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 10'h006);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_sum", sum, 8'h02);
        end
        @(posedge clk);
        #1;
        drain();

        // Reset mid-flight discards the two in-flight beats
        send(1'b0, 8'h10, 8'h10, 1'b0, 1'b0, 10'h020);
        send(1'b0, 8'h20, 8'h20, 1'b0, 1'b0, 10'h040);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("stale_out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // 1-bit sweep against full-adder truth table (add and subtract)
        for (int t = 0; t < 16; t++) begin
            v  = 3'(t);
            rs = (t >= 8);
            x  = rs ? ~v[1] : v[1];
            y  = rs ? ~v[0] : v[0];
            s  = v[2] ^ x ^ y;
            co = (v[2] & x) | (v[2] & y) | (x & y);
            send(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], rs, {y ^ co, co, 7'd0, s});
        end
        idle(1);
        drain();

        // Random stream with bubbles and random backpressure
        rnd_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle($urandom_range(1, 2));
            end else begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                send(1'b0, ra, rb, rc, rs, model(8, int'(ra), int'(rb), int'(rc), int'(rs)));
            end
        end
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        drain();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
